// File: rtl/sram_bus_slave.sv
// Bus-to-async-SRAM bridge: turns single-word bus requests into timed SRAM accesses.
// All SRAM-facing signals are flop outputs, so the strobes cannot glitch.
module sram_bus_slave #(
    parameter int SRAM_AW = 16,
    parameter int WAIT_RD = 1,
    parameter int WAIT_WR = 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [15:0]        i_addr,
    input  logic [15:0]        i_dat,
    output logic [15:0]        o_dat,
    input  logic               i_cs,
    input  logic               i_we,
    output logic               o_ack,
    output logic               o_busy,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [15:0]        o_sram_dq_out,
    output logic               o_sram_dq_oe,
    input  logic [15:0]        i_sram_dq_in,
    output logic               o_sram_ce_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_ACK
    } state_t;

    localparam logic [3:0] WAIT_RD_C = 4'(WAIT_RD);
    localparam logic [3:0] WAIT_WR_C = 4'(WAIT_WR);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [15:0]          dat_q, dat_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [15:0]          dq_out_q, dq_out_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 ce_n_q, ce_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 we_n_q, we_n_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dat_d    = dat_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;

        case (state_q)
            S_IDLE: begin
                if (i_cs) begin
                    addr_d   = i_addr[SRAM_AW-1:0];
                    dq_out_d = i_dat;
                    if (i_we) begin
                        state_d = S_WSETUP;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = WAIT_RD_C;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) begin
                    dat_d   = i_sram_dq_in;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WSETUP: begin
                state_d = S_WPULSE;
                cnt_d   = WAIT_WR_C;
            end
            S_WPULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WHOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WHOLD: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered copies of what the next state requires.
        ce_n_d  = !(state_d == S_RD || state_d == S_WSETUP ||
                    state_d == S_WPULSE || state_d == S_WHOLD);
        oe_n_d  = (state_d != S_RD);
        we_n_d  = (state_d != S_WPULSE);
        dq_oe_d = (state_d == S_WSETUP || state_d == S_WPULSE || state_d == S_WHOLD);
        ack_d   = (state_d == S_ACK);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            dat_q    <= 16'd0;
            addr_q   <= '0;
            dq_out_q <= 16'd0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign o_dat         = dat_q;
    assign o_ack         = ack_q;
    assign o_busy        = busy_q;
    assign o_sram_addr   = addr_q;
    assign o_sram_dq_out = dq_out_q;
    assign o_sram_dq_oe  = dq_oe_q;
    assign o_sram_ce_n   = ce_n_q;
    assign o_sram_oe_n   = oe_n_q;
    assign o_sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_bus_slave.sv
// Directed bench for sram_bus_slave: three instances with wait states (1,1), (0,0), (15,15).
// Instance 0 has an SRAM model; the others return addr^0x5A5A on reads.
module tb_sram_bus_slave;

    logic        clk;
    logic        rst_n  [3];
    logic        cs     [3];
    logic        we     [3];
    logic [15:0] addr   [3];
    logic [15:0] dat    [3];
    logic [15:0] odat   [3];
    logic        ack    [3];
    logic        busy   [3];
    logic [15:0] sa     [3];
    logic [15:0] dq_out [3];
    logic        dq_oe  [3];
    logic [15:0] dq_in  [3];
    logic        ce_n   [3];
    logic        oe_n   [3];
    logic        we_n   [3];

    logic [15:0] mem [0:65535];
    logic        poke;
    logic [15:0] poke_a, poke_d;
    logic        we_n0;

    int total = 0;
    int bad   = 0;

    int r_lat, r_idle, r_oe, r_we, r_ce, r_brk, r_ovl, r_dqoe;
    logic [15:0] r_dat;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        sram_bus_slave #(
            .SRAM_AW(16),
            .WAIT_RD(g == 0 ? 1 : (g == 1 ? 0 : 15)),
            .WAIT_WR(g == 0 ? 1 : (g == 1 ? 0 : 15))
        ) u_dut (
            .i_clk        (clk),
            .i_reset_n    (rst_n[g]),
            .i_addr       (addr[g]),
            .i_dat        (dat[g]),
            .o_dat        (odat[g]),
            .i_cs         (cs[g]),
            .i_we         (we[g]),
            .o_ack        (ack[g]),
            .o_busy       (busy[g]),
            .o_sram_addr  (sa[g]),
            .o_sram_dq_out(dq_out[g]),
            .o_sram_dq_oe (dq_oe[g]),
            .i_sram_dq_in (dq_in[g]),
            .o_sram_ce_n  (ce_n[g]),
            .o_sram_oe_n  (oe_n[g]),
            .o_sram_we_n  (we_n[g])
        );
    end

    assign dq_in[0] = (!ce_n[0] && !oe_n[0]) ? mem[sa[0]] : 16'hDEAD;
    assign dq_in[1] = (!ce_n[1] && !oe_n[1]) ? (sa[1] ^ 16'h5A5A) : 16'hDEAD;
    assign dq_in[2] = (!ce_n[2] && !oe_n[2]) ? (sa[2] ^ 16'h5A5A) : 16'hDEAD;
    assign we_n0 = we_n[0];

    // SRAM latches the word on the rising edge of we_n.
    always @(posedge we_n0 or posedge poke) begin
        if (poke)
            mem[poke_a] <= poke_d;
        else if (!ce_n[0] && dq_oe[0])
            mem[sa[0]] <= dq_out[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke_mem(input logic [15:0] a, input logic [15:0] d);
        poke_a = a;
        poke_d = d;
        poke   = 1'b1;
        #1;
        poke   = 1'b0;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; drives a request and observes until ack.
    task automatic txn(input int g, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input bit keep, input bit drop1, input string tag);
        int n;
        n = 0;
        r_idle = 0; r_oe = 0; r_we = 0; r_ce = 0; r_brk = 0; r_ovl = 0; r_dqoe = 0;
        r_dat = 16'h0;
        cs[g]   = 1'b1;
        we[g]   = w;
        addr[g] = a;
        dat[g]  = d;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (!busy[g] && !ack[g]) r_idle++;
            if (!oe_n[g]) r_oe++;
            if (!we_n[g]) r_we++;
            if (!ce_n[g]) r_ce++;
            if (!ce_n[g] && dq_oe[g] && we_n[g]) r_brk++;
            if (dq_oe[g] && !oe_n[g]) r_ovl++;
            if (dq_oe[g]) r_dqoe++;
            if (drop1 && n == 1) cs[g] = 1'b0;
            if (ack[g]) break;
        end
        check({tag, "_ack"}, 32'(ack[g]), 32'd1);
        r_lat = n - r_idle;
        r_dat = odat[g];
        if (!keep) cs[g] = 1'b0;
    endtask

    initial begin
        int act;
        poke = 1'b0; poke_a = 16'h0; poke_d = 16'h0;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; cs[i] = 1'b0; we[i] = 1'b0; addr[i] = 16'h0; dat[i] = 16'h0;
        end
        poke_mem(16'h0042, 16'h1234);
        idle_cycles(3);
        check("rst_ack",   32'(ack[0]),    32'd0);
        check("rst_busy",  32'(busy[0]),   32'd0);
        check("rst_ce_n",  32'(ce_n[0]),   32'd1);
        check("rst_oe_n",  32'(oe_n[0]),   32'd1);
        check("rst_we_n",  32'(we_n[0]),   32'd1);
        check("rst_dq_oe", 32'(dq_oe[0]),  32'd0);
        check("rst_odat",  32'(odat[0]),   32'd0);
        check("rst_addr",  32'(sa[0]),     32'd0);
        check("rst_dqout", 32'(dq_out[0]), 32'd0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        idle_cycles(2);

        // Read with one wait state
        txn(0, 1'b0, 16'h0042, 16'h0, 1'b0, 1'b0, "rd42");
        check("rd42_lat",  32'(r_lat),  32'd3);
        check("rd42_dat",  32'(r_dat),  32'h1234);
        check("rd42_oe",   32'(r_oe),   32'd2);
        check("rd42_dqoe", 32'(r_dqoe), 32'd0);
        check("rd42_we",   32'(r_we),   32'd0);
        idle_cycles(2);

        // Write with one wait state, then read back
        txn(0, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b0, "wr100");
        check("wr100_lat", 32'(r_lat), 32'd5);
        check("wr100_we",  32'(r_we),  32'd2);
        check("wr100_brk", 32'(r_brk), 32'd2);
        check("wr100_ce",  32'(r_ce),  32'd4);
        check("wr100_oe",  32'(r_oe),  32'd0);
        check("wr100_ovl", 32'(r_ovl), 32'd0);
        idle_cycles(2);
        txn(0, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0, "rb100");
        check("rb100_dat", 32'(r_dat), 32'hBEEF);
        idle_cycles(2);

        // Back-to-back: cs held high across 4 writes and 4 reads
        for (int n = 0; n < 4; n++) begin
            txn(0, 1'b1, 16'(n), 16'hA000 + 16'(n), 1'b1, 1'b0, "b2bw");
            check("b2bw_lat", 32'(r_lat), 32'd5);
            if (n > 0) check("b2bw_idle", 32'(r_idle), 32'd1);
        end
        for (int n = 0; n < 4; n++) begin
            txn(0, 1'b0, 16'(n), 16'h0, (n != 3), 1'b0, "b2br");
            check("b2br_lat",  32'(r_lat),  32'd3);
            check("b2br_idle", 32'(r_idle), 32'd1);
            check("b2br_dat",  32'(r_dat),  32'hA000 + 32'(n));
        end
        idle_cycles(2);

        // Wait-state sweep, 0 and 15
        txn(1, 1'b0, 16'h0007, 16'h0, 1'b0, 1'b0, "w0rd");
        check("w0rd_lat", 32'(r_lat), 32'd2);
        check("w0rd_oe",  32'(r_oe),  32'd1);
        check("w0rd_dat", 32'(r_dat), 32'h5A5D);
        idle_cycles(2);
        txn(1, 1'b1, 16'h0008, 16'h1111, 1'b0, 1'b0, "w0wr");
        check("w0wr_lat", 32'(r_lat), 32'd4);
        check("w0wr_we",  32'(r_we),  32'd1);
        check("w0wr_brk", 32'(r_brk), 32'd2);
        idle_cycles(2);
        txn(2, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, "w15rd");
        check("w15rd_lat", 32'(r_lat), 32'd17);
        check("w15rd_oe",  32'(r_oe),  32'd16);
        check("w15rd_dat", 32'(r_dat), 32'h5A59);
        check("w15rd_ovl", 32'(r_ovl), 32'd0);
        idle_cycles(2);
        txn(2, 1'b1, 16'h0004, 16'h2222, 1'b0, 1'b0, "w15wr");
        check("w15wr_lat", 32'(r_lat), 32'd19);
        check("w15wr_we",  32'(r_we),  32'd16);
        check("w15wr_brk", 32'(r_brk), 32'd2);
        idle_cycles(2);

        // Abort: cs dropped one cycle into a write
        txn(0, 1'b1, 16'h0010, 16'h5555, 1'b0, 1'b1, "abort");
        check("abort_lat", 32'(r_lat), 32'd5);
        act = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy[0] || ack[0]) act++;
        end
        check("abort_quiet", 32'(act), 32'd0);
        check("abort_mem", 32'(mem[16'h0010]), 32'h5555);

        // Async reset in the middle of a long write pulse
        cs[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0020; dat[2] = 16'h7777;
        idle_cycles(6);
        check("rstw_pre_we_n", 32'(we_n[2]), 32'd0);
        #5;
        rst_n[2] = 1'b0;
        #2;
        check("rstw_we_n",  32'(we_n[2]),  32'd1);
        check("rstw_ce_n",  32'(ce_n[2]),  32'd1);
        check("rstw_oe_n",  32'(oe_n[2]),  32'd1);
        check("rstw_dq_oe", 32'(dq_oe[2]), 32'd0);
        cs[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        idle_cycles(2);
        check("rstw_busy", 32'(busy[2]), 32'd0);
        check("rstw_ack",  32'(ack[2]),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
